alarm_clock: RTL and testbench



---
 rtl/alarm_clock.sv | 181 ++++++++++++++++++
 tb/tb_alarm_clock.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock.sv
// 24-hour BCD clock (HH:MM:SS) with one HH:MM alarm and a sticky Alarm output.
// A clk divider produces the one-second tick; every output is a register.
module alarm_clock #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic       LD_time,
  input  logic       LD_alarm,
  input  logic       STOP_al,
  input  logic       AL_ON,
  output logic       Alarm,
  output logic [1:0] H_out1,
  output logic [3:0] H_out0,
  output logic [3:0] M_out1,
  output logic [3:0] M_out0,
  output logic [3:0] S_out1,
  output logic [3:0] S_out0
);

  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

  function automatic logic time_valid(input logic [1:0] h1, input logic [3:0] h0,
                                      input logic [3:0] m1, input logic [3:0] m0);
    return (h1 <= 2'd2) && (h0 <= 4'd9) && (m1 <= 4'd5) && (m0 <= 4'd9) &&
           !((h1 == 2'd2) && (h0 > 4'd3));
  endfunction

  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      h1_q, h1_d;
  logic [3:0]      h0_q, h0_d;
  logic [3:0]      m1_q, m1_d;
  logic [3:0]      m0_q, m0_d;
  logic [3:0]      s1_q, s1_d;
  logic [3:0]      s0_q, s0_d;
  logic [1:0]      al_h1_q, al_h1_d;
  logic [3:0]      al_h0_q, al_h0_d;
  logic [3:0]      al_m1_q, al_m1_d;
  logic [3:0]      al_m0_q, al_m0_d;
  logic            alarm_q, alarm_d;

  logic       in_valid;
  logic       tick;
  logic       s_wrap, m_wrap;
  logic       match;
  logic [1:0] rst_h1;
  logic [3:0] rst_h0, rst_m1, rst_m0;

  assign in_valid = time_valid(H_in1, H_in0, M_in1, M_in0);
  assign tick     = (div_q == DivMax);

  // Out-of-range inputs during reset fall back to midnight.
  assign rst_h1 = in_valid ? H_in1 : 2'd0;
  assign rst_h0 = in_valid ? H_in0 : 4'd0;
  assign rst_m1 = in_valid ? M_in1 : 4'd0;
  assign rst_m0 = in_valid ? M_in0 : 4'd0;

  assign s_wrap = (s1_q == 4'd5) && (s0_q == 4'd9);
  assign m_wrap = (m1_q == 4'd5) && (m0_q == 4'd9);

  assign match = AL_ON && (h1_q == al_h1_q) && (h0_q == al_h0_q) &&
                 (m1_q == al_m1_q) && (m0_q == al_m0_q) &&
                 (s1_q == 4'd0) && (s0_q == 4'd0);

  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    h1_d    = h1_q;
    h0_d    = h0_q;
    m1_d    = m1_q;
    m0_d    = m0_q;
    s1_d    = s1_q;
    s0_d    = s0_q;
    al_h1_d = al_h1_q;
    al_h0_d = al_h0_q;
    al_m1_d = al_m1_q;
    al_m0_d = al_m0_q;

    if (tick) begin
      // Seconds
      if (s0_q == 4'd9) begin
        s0_d = 4'd0;
        s1_d = (s1_q == 4'd5) ? 4'd0 : s1_q + 4'd1;
      end else begin
        s0_d = s0_q + 4'd1;
      end
      // Minutes, on the seconds carry
      if (s_wrap) begin
        if (m0_q == 4'd9) begin
          m0_d = 4'd0;
          m1_d = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
        end else begin
          m0_d = m0_q + 4'd1;
        end
      end
      // Hours, on the minutes carry
      if (s_wrap && m_wrap) begin
        if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
          h1_d = 2'd0;
          h0_d = 4'd0;
        end else if (h0_q == 4'd9) begin
          h1_d = h1_q + 2'd1;
          h0_d = 4'd0;
        end else begin
          h0_d = h0_q + 4'd1;
        end
      end
    end

    // A time load overrides any tick in the same cycle and restarts the second.
    if (LD_time && in_valid) begin
      h1_d  = H_in1;
      h0_d  = H_in0;
      m1_d  = M_in1;
      m0_d  = M_in0;
      s1_d  = 4'd0;
      s0_d  = 4'd0;
      div_d = '0;
    end

    if (LD_alarm && in_valid) begin
      al_h1_d = H_in1;
      al_h0_d = H_in0;
      al_m1_d = M_in1;
      al_m0_d = M_in0;
    end

    if (STOP_al) begin
      alarm_d = 1'b0;
    end else if (!AL_ON) begin
      alarm_d = 1'b0;
    end else if (match) begin
      alarm_d = 1'b1;
    end else begin
      alarm_d = alarm_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      h1_q    <= rst_h1;
      h0_q    <= rst_h0;
      m1_q    <= rst_m1;
      m0_q    <= rst_m0;
      s1_q    <= 4'd0;
      s0_q    <= 4'd0;
      al_h1_q <= 2'd0;
      al_h0_q <= 4'd0;
      al_m1_q <= 4'd0;
      al_m0_q <= 4'd0;
      alarm_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      h1_q    <= h1_d;
      h0_q    <= h0_d;
      m1_q    <= m1_d;
      m0_q    <= m0_d;
      s1_q    <= s1_d;
      s0_q    <= s0_d;
      al_h1_q <= al_h1_d;
      al_h0_q <= al_h0_d;
      al_m1_q <= al_m1_d;
      al_m0_q <= al_m0_d;
      alarm_q <= alarm_d;
    end
  end

  assign Alarm  = alarm_q;
  assign H_out1 = h1_q;
  assign H_out0 = h0_q;
  assign M_out1 = m1_q;
  assign M_out0 = m0_q;
  assign S_out1 = s1_q;
  assign S_out0 = s0_q;

endmodule

// File: tb/tb_alarm_clock.sv
// Directed bench for alarm_clock: counting, roll-overs, loads, alarm and reset behaviour.
module tb_alarm_clock;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, STOP_al, AL_ON;
  logic       Alarm;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;

  int n_checks = 0;
  int n_pass   = 0;

  alarm_clock #(.TICK_DIV(10)) dut (
    .clk(clk), .reset(reset),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al), .AL_ON(AL_ON),
    .Alarm(Alarm),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] tv(input int h1, input int h0, input int m1, input int m0,
                                     input int s1, input int s0);
    return {h1[1:0], h0[3:0], m1[3:0], m0[3:0], s1[3:0], s0[3:0]};
  endfunction

  task automatic chk_time(input string tag, input logic [21:0] exp);
    logic [21:0] got;
    got = {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic chk_alarm(input string tag, input logic exp);
    n_checks++;
    assert (Alarm === exp) n_pass++;
    else $error("FAIL %s: observed Alarm=%b expected %b", tag, Alarm, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input int h1, input int h0, input int m1, input int m0);
    H_in1 = h1[1:0];
    H_in0 = h0[3:0];
    M_in1 = m1[3:0];
    M_in0 = m0[3:0];
  endtask

  // One-cycle LD_time pulse; returns at the negedge after the loading edge.
  task automatic set_time(input int h1, input int h0, input int m1, input int m0);
    set_in(h1, h0, m1, m0);
    LD_time = 1'b1;
    step(1);
    LD_time = 1'b0;
  endtask

  initial begin
    LD_time = 0; LD_alarm = 0; STOP_al = 0; AL_ON = 0;
    set_in(1, 0, 1, 9);
    reset = 1'b1;
    #7;
    chk_time("reset_loads_inputs", tv(1, 0, 1, 9, 0, 0));
    chk_alarm("reset_alarm_low", 1'b0);

    // Release reset and program the alarm for 10:20 in the same cycle.
    @(negedge clk);
    reset = 1'b0;
    set_in(1, 0, 2, 0);
    LD_alarm = 1'b1;
    AL_ON = 1'b1;
    step(1);
    LD_alarm = 1'b0;
    chk_time("ld_alarm_keeps_time", tv(1, 0, 1, 9, 0, 0));
    step(8);
    chk_time("before_first_tick", tv(1, 0, 1, 9, 0, 0));
    step(1);
    chk_time("first_tick", tv(1, 0, 1, 9, 0, 1));
    step(589);
    chk_time("at_10_19_59", tv(1, 0, 1, 9, 5, 9));
    chk_alarm("no_alarm_before_match", 1'b0);
    step(1);
    chk_time("at_10_20_00", tv(1, 0, 2, 0, 0, 0));
    chk_alarm("alarm_registered_late", 1'b0);
    step(1);
    chk_alarm("alarm_rises", 1'b1);
    step(9);
    chk_time("at_10_20_01", tv(1, 0, 2, 0, 0, 1));
    chk_alarm("alarm_sticky", 1'b1);
    step(40);
    chk_alarm("alarm_still_sticky", 1'b1);
    STOP_al = 1'b1;
    step(1);
    chk_alarm("stop_clears", 1'b0);
    step(49);
    chk_alarm("stop_held_low", 1'b0);
    STOP_al = 1'b0;

    // Roll-overs
    set_time(2, 3, 5, 9);
    chk_time("load_23_59", tv(2, 3, 5, 9, 0, 0));
    step(590);
    chk_time("at_23_59_59", tv(2, 3, 5, 9, 5, 9));
    step(10);
    chk_time("roll_midnight", tv(0, 0, 0, 0, 0, 0));
    set_time(0, 9, 5, 9);
    step(590);
    chk_time("at_09_59_59", tv(0, 9, 5, 9, 5, 9));
    step(10);
    chk_time("roll_10_00", tv(1, 0, 0, 0, 0, 0));
    set_time(1, 9, 5, 9);
    step(590);
    chk_time("at_19_59_59", tv(1, 9, 5, 9, 5, 9));
    step(10);
    chk_time("roll_20_00", tv(2, 0, 0, 0, 0, 0));

    // Alarm disabled through the matching second, enabled only afterwards.
    AL_ON = 1'b0;
    set_time(1, 0, 1, 9);
    step(600);
    chk_time("al_off_10_20_00", tv(1, 0, 2, 0, 0, 0));
    step(1);
    chk_alarm("al_off_no_alarm", 1'b0);
    step(10);
    chk_time("al_off_10_20_01", tv(1, 0, 2, 0, 0, 1));
    AL_ON = 1'b1;
    step(5);
    chk_alarm("late_al_on_no_alarm", 1'b0);

    // Invalid loads are ignored.
    set_time(1, 2, 3, 4);
    chk_time("load_12_34", tv(1, 2, 3, 4, 0, 0));
    set_time(2, 4, 0, 0);
    chk_time("reject_24_00", tv(1, 2, 3, 4, 0, 0));
    set_time(1, 2, 6, 5);
    chk_time("reject_min_65", tv(1, 2, 3, 4, 0, 0));
    set_time(0, 10, 0, 0);
    chk_time("reject_hour_digit", tv(1, 2, 3, 4, 0, 0));
    STOP_al = 1'b1;
    set_in(2, 5, 0, 0);
    LD_alarm = 1'b1;
    step(1);
    LD_alarm = 1'b0;
    STOP_al = 1'b0;
    set_time(1, 0, 2, 0);
    chk_alarm("alarm_kept_pre", 1'b0);
    step(1);
    chk_alarm("alarm_regs_kept_10_20", 1'b1);

    // Simultaneous time and alarm load from the same inputs.
    STOP_al = 1'b1;
    set_in(0, 7, 4, 5);
    LD_time = 1'b1;
    LD_alarm = 1'b1;
    step(1);
    LD_time = 1'b0;
    LD_alarm = 1'b0;
    STOP_al = 1'b0;
    chk_time("both_load_time", tv(0, 7, 4, 5, 0, 0));
    chk_alarm("both_load_stop", 1'b0);
    step(1);
    chk_alarm("both_load_match", 1'b1);
    step(25);
    chk_time("mid_count", tv(0, 7, 4, 5, 0, 2));

    // Asynchronous reset in the middle of a second.
    set_in(0, 8, 3, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_time("async_reset_time", tv(0, 8, 3, 0, 0, 0));
    chk_alarm("async_reset_alarm", 1'b0);
    @(negedge clk);
    chk_time("reset_held", tv(0, 8, 3, 0, 0, 0));
    reset = 1'b0;
    set_time(0, 0, 0, 0);
    chk_time("load_midnight", tv(0, 0, 0, 0, 0, 0));
    step(1);
    chk_alarm("reset_alarm_regs_zero", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
